out_arbiter: RTL and testbench
==============================

# out_arbiter

Sequential arbiter that shares one registered 1-bit output `out` among `N_REQ` requesters. Each requester supplies its own drive value, and exactly one owner drives `out` at a time, so the output never has more than one driver. Every state of `out` is defined: the arbiter uses full case coverage and creates no latches. It sits between the requesting processes and the consumer of `out`, and replaces per-process `always` blocks that all write the same register.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `MAX_HOLD`, default 8: maximum consecutive owned cycles before forced release; must be ≥2.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req` input `N_REQ`: per-requester request level; hold high while ownership is wanted.
- `wdata` input `N_REQ`: per-requester drive value; bit i is sampled only while i owns.
- `gnt` output `N_REQ`: registered one-hot grant, or all zero.
- `out` output 1: registered shared output.
- `out_valid` output 1: high while `out` carries a value from the current owner.
- `busy` output 1: high while in OWN state.
- `contend` output 1: one-cycle registered pulse when an arbitration edge sees ≥2 eligible requests.

## Operation
- FSM states are IDLE and OWN. Reset enters IDLE.
- Reset values are all zero: `gnt`=0, `out`=0, `out_valid`=0, `busy`=0, `contend`=0, `hold_cnt`=0, `rr_ptr`=0, `mask`=0.
- IDLE:
  - Eligible set = `req & ~mask`.
  - If the eligible set is non-empty, the next edge does all of the following:
    - selects a winner;
    - sets `gnt`=onehot(winner) and `busy`=1;
    - loads `out` with `wdata[winner]` and sets `out_valid`=1;
    - sets `hold_cnt`=1 and enters OWN.
  - `mask` clears at every IDLE edge.
  - If the eligible set is empty, the FSM stays in IDLE. `out` holds its last value and `out_valid`=0.
- OWN: at each edge, evaluate in this priority order:
  1. `req[owner]`=0 → voluntary release.
  2. `hold_cnt`==`MAX_HOLD` → forced release.
  3. Otherwise `out`←`wdata[owner]` and `hold_cnt`++.
- Release (either kind), at that edge:
  - `gnt`←0, `busy`←0, `out_valid`←0, and the FSM enters IDLE.
  - `out` keeps the last owned value.
  - `rr_ptr`←(owner+1) mod `N_REQ`.
  - Forced release only: `mask`←onehot(owner) for the next IDLE cycle.
- Every release therefore produces at least one cycle with `gnt`=0 before the next grant.
- `wdata` of non-owners is ignored. A non-owner `req` in OWN has no effect until IDLE.
- `contend` is registered on the IDLE edge that grants, from popcount(eligible)≥2. It is 0 otherwise.
- `hold_cnt` width is $clog2(`MAX_HOLD`+1). It never exceeds `MAX_HOLD`.

## Timing
- Grant latency: `req[i]` high before edge k in IDLE → `gnt[i]` and first `out` value visible after edge k (1 cycle).
- Data latency in OWN: `wdata[owner]` before edge k appears on `out` after edge k.
- Maximum ownership: `MAX_HOLD` consecutive cycles with `gnt` high.
- Re-grant after release: the earliest new `gnt` is 2 edges after the release edge's preceding cycle (one gnt-free cycle).
- Simultaneous events:
  - `req[owner]` falling on the same edge where `hold_cnt`==`MAX_HOLD` counts as voluntary release; no `mask` is set.
  - A masked sole requester is granted on the second IDLE edge.
- `rst_n` asserted mid-OWN immediately clears all outputs and state, with no clock required. Deassertion is synchronous to `clk` at the system level.

## Configuration
- Macro: `OUT_ARB_ROUND_ROBIN_EN`.
- Defined: the winner is the first eligible index searching upward from `rr_ptr`, wrapping at `N_REQ`-1→0.
- Undefined:
  - Fixed priority: the lowest eligible index wins.
  - `rr_ptr` logic is removed and reads as 0.
  - The forced-release `mask` is still applied, so starvation is bounded only for `MAX_HOLD` abuse.

## Test plan
- Reset mid-OWN: owner 2 holding, `out`=1, `rst_n` low → `gnt`=0, `out`=0, `out_valid`=0, `busy`=0 with no clock edge.
- Single requester: `req`=0001, `wdata[0]` toggling 1,0,1 → `gnt`=0001 after 1 edge; `out` follows 1,0,1 one edge late; `req` drop → `gnt`=0 next edge, `out` holds the last value.
- Forced release: `req`=0010 held with `MAX_HOLD`=8 → `gnt[1]` high exactly 8 cycles, then 2 IDLE cycles (mask), then re-granted.
- Contention, round-robin: `req`=1111 held, each owner drops after 2 cycles → grant order 0,1,2,3,0; `contend` pulses on each grant.
- Contention, fixed priority (macro undefined): `req`=0110 held, each owner drops after 2 cycles and re-raises → index 1 always wins; `contend`=1 on each grant.
- Coincident release: `req[owner]` falls on the `hold_cnt`==`MAX_HOLD` edge → `mask` stays 0; another waiting requester is granted on the next edge.

Source files
------------

// File: rtl/out_arbiter.sv
// Arbitrates one registered 1-bit output among N_REQ requesters, with a hold limit and forced release.
// Define OUT_ARB_ROUND_ROBIN_EN for round-robin winner selection; the default build uses fixed priority.
module out_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] wdata,
  output logic [N_REQ-1:0] gnt,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             contend
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_mask;
  logic             r_out;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_contend;
  logic [HW-1:0]    r_hold_cnt;
  logic [IW-1:0]    r_owner;

  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_win_oh;
  logic [N_REQ-1:0] w_own_oh;
  logic [IW-1:0]    w_winner;
  logic             w_any;
  logic             w_release;

  assign w_elig    = req & ~r_mask;
  assign w_any     = |w_elig;
  assign w_win_oh  = N_REQ'(1) << w_winner;
  assign w_own_oh  = N_REQ'(1) << r_owner;
  assign w_release = !req[r_owner] || (r_hold_cnt == HOLD_MAX);

`ifdef OUT_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] r_rr_ptr;

  // First eligible index at or above r_rr_ptr, wrapping to 0.
  always_comb begin
    logic [IW:0] sum;
    logic        found;
    sum      = '0;
    found    = 1'b0;
    w_winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      if (!found && w_elig[sum[IW-1:0]]) begin
        w_winner = sum[IW-1:0];
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (r_state == S_OWN && w_release) begin
      r_rr_ptr <= (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
    end
  end
`else
  always_comb begin
    w_winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_elig[k]) w_winner = IW'(k);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_mask      <= '0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_contend   <= 1'b0;
      r_hold_cnt  <= '0;
      r_owner     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_mask <= '0;
          if (w_any) begin
            r_state     <= S_OWN;
            r_owner     <= w_winner;
            r_gnt       <= w_win_oh;
            r_busy      <= 1'b1;
            r_out       <= wdata[w_winner];
            r_out_valid <= 1'b1;
            r_hold_cnt  <= HW'(1);
            r_contend   <= ($countones(w_elig) > 1);
          end else begin
            r_out_valid <= 1'b0;
            r_contend   <= 1'b0;
          end
        end
        S_OWN: begin
          r_contend <= 1'b0;
          if (w_release) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_hold_cnt  <= '0;
            // A request still held at the limit is a forced release: bar it for one IDLE edge.
            r_mask      <= req[r_owner] ? w_own_oh : '0;
          end else begin
            r_out      <= wdata[r_owner];
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign contend   = r_contend;

endmodule

// File: tb/tb_out_arbiter.sv
// Directed bench for out_arbiter (N_REQ=4, MAX_HOLD=8): vector table plus multi-cycle sequences.
module tb_out_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] wdata;
  logic [3:0] gnt;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       contend;

  int n_pass  = 0;
  int n_total = 0;

  out_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .wdata     (wdata),
    .gnt       (gnt),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .contend   (contend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] wdata;
    logic [3:0] gnt;
    logic       out;
    logic       ov;
    logic       busy;
    logic       cont;
  } vec_t;

  vec_t vecs[12];

  task automatic step(input logic [3:0] r, input logic [3:0] w);
    @(negedge clk);
    req   = r;
    wdata = w;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] w, input logic [3:0] g,
                              input logic o, input logic v, input logic b, input logic c);
    vec_t t;
    t.req = r; t.wdata = w; t.gnt = g; t.out = o; t.ov = v; t.busy = b; t.cont = c;
    return t;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] oh;
    rst_n = 1'b0;
    req   = '0;
    wdata = '0;

    // req, wdata -> gnt, out, out_valid, busy, contend
    vecs[0]  = mk(4'b0001, 4'b0001, 4'b0001, 1, 1, 1, 0);
    vecs[1]  = mk(4'b0001, 4'b0000, 4'b0001, 0, 1, 1, 0);
    vecs[2]  = mk(4'b0001, 4'b0001, 4'b0001, 1, 1, 1, 0);
    vecs[3]  = mk(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0);
    vecs[4]  = mk(4'b0000, 4'b1111, 4'b0000, 1, 0, 0, 0);
    vecs[5]  = mk(4'b0110, 4'b0100, 4'b0010, 0, 1, 1, 1);
    vecs[6]  = mk(4'b0110, 4'b0010, 4'b0010, 1, 1, 1, 0);
    vecs[7]  = mk(4'b0100, 4'b0010, 4'b0000, 1, 0, 0, 0);
`ifdef OUT_ARB_ROUND_ROBIN_EN
    vecs[8]  = mk(4'b0110, 4'b0000, 4'b0100, 0, 1, 1, 1);
    vecs[9]  = mk(4'b0100, 4'b0100, 4'b0100, 1, 1, 1, 0);
    vecs[10] = mk(4'b0000, 4'b0100, 4'b0000, 1, 0, 0, 0);
    vecs[11] = mk(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0);
`else
    vecs[8]  = mk(4'b0110, 4'b0000, 4'b0010, 0, 1, 1, 1);
    vecs[9]  = mk(4'b0100, 4'b0100, 4'b0000, 0, 0, 0, 0);
    vecs[10] = mk(4'b0100, 4'b0100, 4'b0100, 1, 1, 1, 0);
    vecs[11] = mk(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {24'd0, gnt, out, out_valid, busy, contend}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].req, vecs[i].wdata);
      chk($sformatf("vec%0d", i), {24'd0, gnt, out, out_valid, busy, contend},
          {24'd0, vecs[i].gnt, vecs[i].out, vecs[i].ov, vecs[i].busy, vecs[i].cont});
    end

    // Forced release: eight owned cycles, one masked IDLE cycle, then a re-grant.
    for (int i = 0; i < 8; i++) begin
      step(4'b0010, 4'b0010);
      chk($sformatf("force_own%0d", i), {28'd0, gnt}, 32'b0010);
    end
    chk("force_contend", {31'd0, contend}, 32'd0);
    step(4'b0010, 4'b0000);
    chk("force_release", {28'd0, gnt, out, out_valid, busy, contend}, {28'd0, 4'b0000, 4'b1000});
    step(4'b0010, 4'b0000);
    chk("force_masked", {28'd0, gnt}, 32'd0);
    step(4'b0010, 4'b0010);
    chk("force_regrant", {28'd0, gnt, out}, {27'd0, 4'b0010, 1'b1});
    step(4'b0000, 4'b0000);
    chk("force_drop", {28'd0, gnt}, 32'd0);

    // Coincident release: request falls on the limit edge, so no mask is left behind.
    for (int i = 0; i < 8; i++) begin
      step(4'b0010, 4'b0000);
      chk($sformatf("coin_own%0d", i), {28'd0, gnt}, 32'b0010);
    end
    step(4'b1000, 4'b0000);
    chk("coin_release", {31'd0, busy}, 32'd0);
    step(4'b0010, 4'b0010);
    chk("coin_regrant", {28'd0, gnt, out}, {27'd0, 4'b0010, 1'b1});

    // Asynchronous reset while owner 2 holds out=1.
    step(4'b0000, 4'b0000);
    step(4'b0100, 4'b0100);
    chk("pre_reset_own", {28'd0, gnt, out}, {27'd0, 4'b0100, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("async_reset", {24'd0, gnt, out, out_valid, busy, contend}, 32'd0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef OUT_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << (i % 4);
      step(4'b1111, oh);
      chk($sformatf("rr_grant%0d", i), {24'd0, gnt, out, 2'b00, contend}, {24'd0, oh, 1'b1, 2'b00, 1'b1});
      step(4'b1111, oh);
      step(4'b1111 & ~oh, 4'b0000);
      chk($sformatf("rr_release%0d", i), {28'd0, gnt}, 32'd0);
    end
`else
    oh = 4'b0000;
    step(4'b0110, 4'b0010);
    chk("fp_grant", {27'd0, gnt, contend}, {27'd0, 4'b0010, 1'b1});
    step(oh, 4'b0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
